// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin scheduler sharing one 4:1 data mux between four
// packet-framed requesters. The select pair is locked for a whole packet, and
// every granted beat lands in a single registered output stage that drains
// through a valid/ready handshake. out_bar is the complement of the stage.
module mux4_rr_sched #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic [3:0]        last,
    output logic [3:0]        gnt,
    output logic              s1,
    output logic              s0,
    output logic              out_valid,
    output logic [DATA_W-1:0] out,
    output logic [DATA_W-1:0] out_bar,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            state_r;
    logic [1:0]        sel_r;
    logic [1:0]        ptr_r;
    logic [DATA_W-1:0] out_r;
    logic              out_valid_r;
    logic              out_last_r;

    logic [1:0]        winner_s;
    logic              any_req_s;
    logic [3:0]        gnt_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_last_s;
    logic              sel_req_s;
    logic              xfer_s;
    logic              accept_s;

    // First requester found scanning p, p+1, ... (mod 4); returns p if none.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + k[1:0];
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
                found = found;
            end
        end
        return res;
    endfunction

    // Arbitration winner for the next packet (only used while idle).
    always_comb begin
        any_req_s = |req;
        winner_s  = rr_pick(req, ptr_r);
    end

    // Data/last/req of the locked requester, steered by the registered select.
    always_comb begin
        sel_data_s = i0;
        sel_last_s = 1'b0;
        sel_req_s  = 1'b0;
        case (sel_r)
            2'd0: begin sel_data_s = i0; sel_last_s = last[0]; sel_req_s = req[0]; end
            2'd1: begin sel_data_s = i1; sel_last_s = last[1]; sel_req_s = req[1]; end
            2'd2: begin sel_data_s = i2; sel_last_s = last[2]; sel_req_s = req[2]; end
            2'd3: begin sel_data_s = i3; sel_last_s = last[3]; sel_req_s = req[3]; end
            default: begin sel_data_s = i0; sel_last_s = 1'b0; sel_req_s = 1'b0; end
        endcase
    end

    // Grant the locked requester whenever the output stage can take a beat.
    always_comb begin
        gnt_s = 4'b0000;
        if (state_r == ST_LOCK) begin
            gnt_s[sel_r] = ~out_valid_r | out_ready;
        end else begin
            gnt_s = 4'b0000;
        end
        xfer_s   = (state_r == ST_LOCK) & sel_req_s & gnt_s[sel_r];
        accept_s = out_valid_r & out_ready;
    end

    // Packet-level control: pick a winner when idle, release the lock on last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_r   <= 2'd0;
            ptr_r   <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        sel_r   <= winner_s;
                        state_r <= ST_LOCK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (xfer_s && sel_last_s) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= sel_r + 2'd1;
                    end else begin
                        state_r <= ST_LOCK;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Output stage: load on transfer, otherwise empty on downstream accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r       <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_r       <= sel_data_s;
            out_last_r  <= sel_last_s;
            out_valid_r <= 1'b1;
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign gnt       = gnt_s;
    assign s1        = sel_r[1];
    assign s0        = sel_r[0];
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign out_bar   = ~out_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched: directed scenarios followed by a
// randomized phase, all checked every cycle against a packet-level model.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [7:0] din [4];
    logic       out_ready;
    logic [3:0] gnt;
    logic       s1, s0, out_valid, out_last;
    logic [7:0] out, out_bar;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner of the current packet (-1 = nobody), rotation
    // start, last select, and the single-entry output holding stage.
    int         m_owner;
    int         m_ptr;
    int         m_sel;
    bit         m_ov;
    logic [7:0] m_out;
    bit         m_last;

    bit rec;
    int grant_q[$];
    int sel_q[$];

    mux4_rr_sched #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .last(last), .gnt(gnt), .s1(s1), .s0(s0),
        .out_valid(out_valid), .out(out), .out_bar(out_bar),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_ov    = 1'b0;
        m_out   = 8'h00;
        m_last  = 1'b0;
    endtask

    // Compare every output against the model, then optionally log grants.
    task automatic settle();
        logic [3:0] exp_gnt;
        logic [7:0] exp_bar;
        #1;
        exp_gnt = 4'b0000;
        if (m_owner >= 0 && (!m_ov || out_ready)) exp_gnt[m_owner] = 1'b1;
        exp_bar = ~m_out;
        check("gnt", gnt, exp_gnt);
        check("sel", {s1, s0}, m_sel);
        check("out_valid", out_valid, m_ov);
        check("out", out, m_out);
        check("out_bar", out_bar, exp_bar);
        check("out_last", out_last, m_last);
        if (rec && gnt != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (gnt[k]) begin
                    grant_q.push_back(k);
                    sel_q.push_back({30'd0, s1, s0});
                end
            end
        end
    endtask

    // Clock edge, then advance the model with the inputs held over that edge.
    task automatic advance();
        int  o;
        bit  take;
        bit  found;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            o    = m_owner;
            take = (o >= 0) && (!m_ov || out_ready) && req[o];
            if (take) begin
                m_out  = din[o];
                m_last = last[o];
                m_ov   = 1'b1;
                if (last[o]) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % 4;
                end
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (o < 0 && req != 4'b0000) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        found   = 1'b1;
                        m_owner = (m_ptr + k) % 4;
                        m_sel   = m_owner;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = 8'h00;
        rec = 1'b0;
        model_reset();
        @(negedge clk);
        advance();
        rst = 1'b0;

        // Reset state
        settle();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_bar", out_bar, 8'hFF);
        check("rst_valid", out_valid, 1'b0);

        // Single-beat packet from requester 0
        req = 4'b0001; last = 4'b0001; din[0] = 8'hA5; out_ready = 1'b1;
        settle(); advance();
        settle(); check("t1_gnt_c2", gnt, 4'b0001); advance();
        req = 4'b0000; last = 4'b0000;
        settle();
        check("t1_out", out, 8'hA5);
        check("t1_bar", out_bar, 8'h5A);
        check("t1_valid", out_valid, 1'b1);
        check("t1_last", out_last, 1'b1);
        advance();

        // All requesting single-beat packets: rotation 0,1,2,3,0
        do_reset();
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        rec = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
            settle(); advance();
        end
        rec = 1'b0;
        check("t2_ngrants", grant_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_q.size()) begin
                check("t2_order", grant_q[k], k % 4);
                check("t2_sel", sel_q[k], k % 4);
            end
        end

        // Three-beat packet from requester 2 cannot be preempted by requester 0
        do_reset();
        req = 4'b0100; last = 4'b0000; din[2] = 8'h11;
        settle(); advance();
        req = 4'b0101;
        settle(); check("t3_sel", {s1, s0}, 2'b10); check("t3_gnt", gnt, 4'b0100); advance();
        din[2] = 8'h22;
        settle(); check("t3_out11", out, 8'h11); check("t3_gnt", gnt, 4'b0100); advance();
        din[2] = 8'h33; last = 4'b0100;
        settle(); check("t3_out22", out, 8'h22); check("t3_gnt", gnt, 4'b0100); advance();
        req = 4'b0001; last = 4'b0000;
        settle(); check("t3_out33", out, 8'h33); check("t3_idle_gnt", gnt, 4'b0000); advance();
        settle(); check("t3_gnt0", gnt, 4'b0001); check("t3_sel0", {s1, s0}, 2'b00); advance();

        // Downstream stall mid-packet
        do_reset();
        req = 4'b0010; last = 4'b0000; din[1] = 8'h40;
        settle(); advance();
        settle(); check("t4_gnt", gnt, 4'b0010); advance();
        out_ready = 1'b0; din[1] = 8'h41;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("t4_stall_gnt", gnt, 4'b0000);
            check("t4_stall_out", out, 8'h40);
            check("t4_stall_valid", out_valid, 1'b1);
            advance();
        end
        out_ready = 1'b1;
        settle(); check("t4_resume_gnt", gnt, 4'b0010); advance();
        din[1] = 8'h42; last = 4'b0010;
        settle(); check("t4_out41", out, 8'h41); advance();
        req = 4'b0000; last = 4'b0000;
        settle(); check("t4_out42", out, 8'h42); check("t4_last", out_last, 1'b1); advance();

        // Bubble on the locked requester while others request
        do_reset();
        req = 4'b0001; last = 4'b0000; din[0] = 8'h50;
        settle(); advance();
        settle(); advance();
        req = 4'b1110;
        for (int c = 0; c < 2; c++) begin
            settle();
            check("t5_gnt", gnt, 4'b0001);
            check("t5_sel", {s1, s0}, 2'b00);
            advance();
        end
        req = 4'b1111; last = 4'b0001; din[0] = 8'h51;
        settle(); advance();
        req = 4'b1110; last = 4'b0000;
        settle(); check("t5_out51", out, 8'h51); advance();
        settle(); check("t5_next", gnt, 4'b0010); advance();

        // Reset while locked with a beat held
        do_reset();
        req = 4'b1000; last = 4'b0000; din[3] = 8'h60;
        settle(); advance();
        settle(); advance();
        out_ready = 1'b0;
        settle(); check("t6_held", out_valid, 1'b1); check("t6_sel", {s1, s0}, 2'b11);
        rst = 1'b1;
        advance();
        rst = 1'b0; req = 4'b1111; out_ready = 1'b1;
        settle();
        check("t6_sel_rst", {s1, s0}, 2'b00);
        check("t6_valid_rst", out_valid, 1'b0);
        check("t6_out_rst", out, 8'h00);
        check("t6_bar_rst", out_bar, 8'hFF);
        advance();
        settle(); check("t6_ptr0", gnt, 4'b0001); advance();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            req       = 4'($urandom);
            last      = 4'($urandom) & 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
            settle(); advance();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
